// File: rtl/tinyenc_if.sv
// Bundles the block request/response handshake and the APB-style config port
// of the tinyenc encryptor. The master side drives requests and config
// accesses, while the slave side is the encryptor itself.
interface tinyenc_if;
  logic        req;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;

  modport master (
    output req, wdata, psel, penable, pwrite, paddr, pwdata,
    input  ack, rdata, prdata, pready
  );

  modport slave (
    input  req, wdata, psel, penable, pwrite, paddr, pwdata,
    output ack, rdata, prdata, pready
  );
endinterface

// File: rtl/tinyenc.sv
// tinyenc: iterative TEA-style 32-bit block encryptor (16-bit halves, 64-bit
// key), one round per clock. A block is loaded when idle and req is seen.
// Its result appears ROUND cycles later, and ack rises on that same cycle.
// Key and delta live in host-writable registers. They share a register map
// with the TEA decryptor. Each block works from a private snapshot taken at
// load, so host writes never disturb a block in flight.
module tinyenc #(
  parameter logic [63:0] KEY   = 64'h816fc52b09e74da3,
  parameter logic [15:0] DELTA = 16'h1,
  parameter logic [7:0]  ROUND = 8'd5
) (
  input  logic      clk,
  input  logic      rst,
  tinyenc_if.slave  bus
);

  // Host-visible configuration
  logic [15:0] k0, k1, k2, k3, delta;
  // Per-block snapshot used by the round engine
  logic [15:0] wk0, wk1, wk2, wk3, wdelta;
  // Round state
  logic [15:0] x, y, sum;
  logic [7:0]  i;
  logic [31:0] rdata;
  logic [31:0] prdata;
  // Next-round values
  logic [15:0] sum_n, x_n, y_n;
  logic        ack;

  // Round mixing function. All terms wrap modulo 2^16, and the right shift is logical.
  function automatic logic [15:0] round_f(input logic [15:0] v,
                                          input logic [15:0] a,
                                          input logic [15:0] b,
                                          input logic [15:0] s);
    logic [15:0] t_shl, t_add, t_shr;
    t_shl = (v << 4) + a;
    t_add = v + s;
    t_shr = (v >> 5) + b;
    return t_shl ^ t_add ^ t_shr;
  endfunction

  // One full round. The y half mixes in the freshly updated x half.
  always_comb begin
    sum_n = sum + wdelta;
    x_n   = x + round_f(y, wk0, wk1, sum_n);
    y_n   = y + round_f(x_n, wk2, wk3, sum_n);
  end

  assign ack        = (i == 8'd0);
  assign bus.ack    = ack;
  assign bus.rdata  = rdata;
  assign bus.prdata = prdata;
  assign bus.pready = 1'b1;

  // Round engine: load on idle+req, then iterate until the counter drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i      <= 8'd0;
      x      <= 16'h0;
      y      <= 16'h0;
      sum    <= 16'h0;
      wk0    <= 16'h0;
      wk1    <= 16'h0;
      wk2    <= 16'h0;
      wk3    <= 16'h0;
      wdelta <= 16'h0;
      rdata  <= 32'h0;
    end else if (i == 8'd0) begin
      if (bus.req) begin
        i      <= ROUND;
        y      <= bus.wdata[31:16];
        x      <= bus.wdata[15:0];
        sum    <= 16'h0;
        wk0    <= k0;
        wk1    <= k1;
        wk2    <= k2;
        wk3    <= k3;
        wdelta <= delta;
      end
    end else begin
      sum <= sum_n;
      x   <= x_n;
      y   <= y_n;
      i   <= i - 8'd1;
      // The last round publishes directly, so ack and rdata rise together.
      if (i == 8'd1) begin
        rdata <= {y_n, x_n};
      end
    end
  end

  // Config port: every selected cycle refreshes the read data, and the access
  // phase of a write updates the register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k0     <= KEY[15:0];
      k1     <= KEY[31:16];
      k2     <= KEY[47:32];
      k3     <= KEY[63:48];
      delta  <= DELTA;
      prdata <= 32'h0;
    end else if (bus.psel) begin
      case (bus.paddr)
        32'h0:   prdata <= {k1, k0};
        32'h4:   prdata <= {k3, k2};
        32'h8:   prdata <= {16'h0, delta};
        32'hC:   prdata <= {31'h0, ack};
        default: prdata <= 32'h0;
      endcase
      if (bus.penable && bus.pwrite) begin
        case (bus.paddr)
          32'h0:   {k1, k0} <= bus.pwdata;
          32'h4:   {k3, k2} <= bus.pwdata;
          32'h8:   delta    <= bus.pwdata[15:0];
          default: ;
        endcase
      end
    end
  end

endmodule
